// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared widths and active-low seven-segment constants
package stopwatch_pkg;
  localparam int DIGIT_W = 4;
  typedef logic [DIGIT_W-1:0] digit_t;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF = 4'b1111;
endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: BCD digit to active-low {g,f,e,d,c,b,a}; illegal codes go dark
module bcd_to_seg
  import stopwatch_pkg::*;
(
  input  digit_t     digit,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/display_mux.sv
// display_mux: four-digit common-anode scanner with per-frame snapshot and adjust blink
module display_mux
  import stopwatch_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  digit_t     minutes_top_digit,
  input  digit_t     minutes_bot_digit,
  input  digit_t     seconds_top_digit,
  input  digit_t     seconds_bot_digit,
  input  logic       is_minute_increasing,
  input  logic       is_second_increasing,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [RW-1:0] R_TC = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] B_TC = BW'(BLINK_DIV - 1);
  logic [RW-1:0] refresh_cnt;
  logic [BW-1:0] blink_cnt;
  logic blink_phase;
  logic [1:0] idx;
  logic [3:0][DIGIT_W-1:0] snap;
  logic [6:0] dec;
  logic r_tc, b_tc, blank;
  assign r_tc = refresh_cnt == R_TC;
  assign b_tc = blink_cnt == B_TC;
  assign blank = blink_phase && (idx[1] ? is_minute_increasing : is_second_increasing);
  bcd_to_seg u_dec (.digit(snap[idx]), .seg(dec));
  // Snapshot only refreshes on entry to slot 0 so a frame never mixes two counts
  always_ff @(posedge clk)
    if (rst || (r_tc && idx == 2'd3))
      snap <= {minutes_top_digit, minutes_bot_digit, seconds_top_digit, seconds_bot_digit};
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      blink_cnt <= '0;
      blink_phase <= 1'b0;
      idx <= 2'd0;
      an <= AN_OFF;
      seg <= SEG_BLANK;
      dp <= 1'b1;
    end else begin
      refresh_cnt <= r_tc ? '0 : refresh_cnt + RW'(1);
      blink_cnt <= b_tc ? '0 : blink_cnt + BW'(1);
      blink_phase <= blink_phase ^ b_tc;
      idx <= r_tc ? idx + 2'd1 : idx;
      an <= blank ? AN_OFF : ~(4'b0001 << idx);
      seg <= blank ? SEG_BLANK : dec;
      dp <= blank || idx != 2'd2;
    end
  end
endmodule

// File: tb/tb_display_mux.sv
// tb_display_mux: directed scenarios for the scanner at REFRESH_DIV=4, BLINK_DIV=16
module tb_display_mux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] mt = 4'd1, mb = 4'd2, st = 4'd3, sb = 4'd4;
  logic min_inc = 1'b0, sec_inc = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp;
  int checks = 0;
  int errors = 0;
  int k = -1;
  logic [3:0] scan_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] scan_seg [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

  display_mux #(.REFRESH_DIV(4), .BLINK_DIV(16)) dut (
    .clk(clk), .rst(rst),
    .minutes_top_digit(mt), .minutes_bot_digit(mb),
    .seconds_top_digit(st), .seconds_bot_digit(sb),
    .is_minute_increasing(min_inc), .is_second_increasing(sec_inc),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    k++;
  endtask

  task automatic run_to(input int target);
    while (k < target) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (an !== 4'b1111) begin errors++; $display("FAIL reset_an got %b want 1111", an); end
    checks++;
    if (seg !== 7'b1111111) begin errors++; $display("FAIL reset_seg got %b want 1111111", seg); end
    checks++;
    if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b want 1", dp); end
    rst = 1'b0;
    k = -1;
  endtask

  task automatic test_scan();
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (an !== scan_an[(k / 4) % 4] || seg !== scan_seg[(k / 4) % 4] || dp !== ((k / 4) % 4 != 2)) begin
        errors++;
        $display("FAIL scan k=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", k, an, seg, dp,
                 scan_an[(k / 4) % 4], scan_seg[(k / 4) % 4], (k / 4) % 4 != 2);
      end
    end
  endtask

  task automatic test_snapshot();
    run_to(33);
    sb = 4'd5;
    for (int t = 34; t <= 35; t++) begin
      run_to(t);
      checks++;
      if (an !== 4'b1110 || seg !== 7'b0011001) begin
        errors++; $display("FAIL snap_hold k=%0d got an=%b seg=%b want an=1110 seg=0011001", k, an, seg);
      end
    end
    run_to(37);
    checks++;
    if (an !== 4'b1101 || seg !== 7'b0110000) begin
      errors++; $display("FAIL snap_slot1 got an=%b seg=%b want an=1101 seg=0110000", an, seg);
    end
    run_to(48);
    checks++;
    if (an !== 4'b1110 || seg !== 7'b0010010) begin
      errors++; $display("FAIL snap_update got an=%b seg=%b want an=1110 seg=0010010", an, seg);
    end
  endtask

  task automatic test_blink();
    min_inc = 1'b1;
    run_to(52);
    checks++;
    if (an !== 4'b1101 || seg !== 7'b0110000) begin
      errors++; $display("FAIL blink_sec_unaffected got an=%b seg=%b want an=1101 seg=0110000", an, seg);
    end
    run_to(56);
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
      errors++; $display("FAIL blink_min_dark got an=%b seg=%b dp=%b want 1111/1111111/1", an, seg, dp);
    end
    run_to(57);
    min_inc = 1'b0;
    run_to(58);
    checks++;
    if (an !== 4'b1011 || seg !== 7'b0100100 || dp !== 1'b0) begin
      errors++; $display("FAIL flag_clear_immediate got an=%b seg=%b dp=%b want 1011/0100100/0", an, seg, dp);
    end
    min_inc = 1'b1;
    run_to(59);
    checks++;
    if (an !== 4'b1111) begin errors++; $display("FAIL flag_set_immediate got an=%b want 1111", an); end
    run_to(60);
    checks++;
    if (an !== 4'b1111) begin errors++; $display("FAIL blink_slot3_dark got an=%b want 1111", an); end
    run_to(64);
    checks++;
    if (an !== 4'b1110 || seg !== 7'b0010010) begin
      errors++; $display("FAIL blink_off_slot0 got an=%b seg=%b want an=1110 seg=0010010", an, seg);
    end
    run_to(72);
    checks++;
    if (an !== 4'b1011 || dp !== 1'b0) begin
      errors++; $display("FAIL blink_off_slot2 got an=%b dp=%b want an=1011 dp=0", an, dp);
    end
    sec_inc = 1'b1;
    for (int t = 80; t <= 92; t += 4) begin
      run_to(t);
      checks++;
      if (an !== 4'b1111 || seg !== 7'b1111111) begin
        errors++; $display("FAIL blink_both k=%0d got an=%b seg=%b want 1111/1111111", k, an, seg);
      end
    end
    run_to(96);
    checks++;
    if (an !== 4'b1110 || seg !== 7'b0010010) begin
      errors++; $display("FAIL blink_both_on got an=%b seg=%b want an=1110 seg=0010010", an, seg);
    end
    min_inc = 1'b0;
    sec_inc = 1'b0;
  endtask

  task automatic test_illegal();
    mt = 4'hC;
    run_to(108);
    checks++;
    if (an !== 4'b0111 || seg !== 7'b1111001) begin
      errors++; $display("FAIL illegal_old_frame got an=%b seg=%b want an=0111 seg=1111001", an, seg);
    end
    run_to(124);
    checks++;
    if (an !== 4'b0111 || seg !== 7'b1111111 || dp !== 1'b1) begin
      errors++; $display("FAIL illegal_digit got an=%b seg=%b dp=%b want 0111/1111111/1", an, seg, dp);
    end
  endtask

  task automatic test_reset_mid();
    run_to(138);
    rst = 1'b1;
    mt = 4'd0; mb = 4'd9; st = 4'd8; sb = 4'd7;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
        errors++; $display("FAIL mid_reset_dark cyc=%0d got %b/%b/%b want 1111/1111111/1", i, an, seg, dp);
      end
    end
    rst = 1'b0;
    k = -1;
    for (int t = 0; t < 4; t++) begin
      run_to(t);
      checks++;
      if (an !== 4'b1110 || seg !== 7'b1111000) begin
        errors++; $display("FAIL post_reset_slot0 k=%0d got an=%b seg=%b want an=1110 seg=1111000", k, an, seg);
      end
    end
    run_to(4);
    checks++;
    if (an !== 4'b1101 || seg !== 7'b0000000) begin
      errors++; $display("FAIL post_reset_slot1 got an=%b seg=%b want an=1101 seg=0000000", an, seg);
    end
    run_to(8);
    checks++;
    if (an !== 4'b1011 || seg !== 7'b0010000 || dp !== 1'b0) begin
      errors++; $display("FAIL post_reset_slot2 got %b/%b/%b want 1011/0010000/0", an, seg, dp);
    end
    run_to(12);
    checks++;
    if (an !== 4'b0111 || seg !== 7'b1000000) begin
      errors++; $display("FAIL post_reset_slot3 got an=%b seg=%b want an=0111 seg=1000000", an, seg);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_snapshot();
    test_blink();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
